// File: rtl/uart_rx_data_bits.sv
// UART receiver: start bit, NrOfDataBits data bits LSB first, one stop bit.
// Presents the received word with a one-cycle dataValid pulse or a framingError pulse.
module uart_rx_data_bits #(
    parameter int ClockFrequency = 1000000,
    parameter int BaudRate       = 9600,
    parameter int NrOfDataBits   = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    rx,
    output logic [NrOfDataBits-1:0] data,
    output logic                    dataValid,
    output logic                    framingError,
    output logic                    busy
);

    localparam int ClocksPerBit = ClockFrequency / BaudRate;
    localparam int HalfBit      = ClocksPerBit / 2;
    localparam int CntW         = (ClocksPerBit > 2) ? $clog2(ClocksPerBit) : 2;
    localparam int BitW         = (NrOfDataBits > 1) ? $clog2(NrOfDataBits) : 1;

    localparam logic [CntW-1:0] LastClk = CntW'(ClocksPerBit - 1);
    localparam logic [CntW-1:0] HalfClk = CntW'(HalfBit - 1);
    localparam logic [CntW-1:0] OneClk  = CntW'(1);
    localparam logic [BitW-1:0] LastBit = BitW'(NrOfDataBits - 1);
    localparam logic [BitW-1:0] OneBit  = BitW'(1);

    localparam logic [1:0] StateIdle  = 2'd0;
    localparam logic [1:0] StateStart = 2'd1;
    localparam logic [1:0] StateData  = 2'd2;
    localparam logic [1:0] StateStop  = 2'd3;

    if (ClocksPerBit < 4) begin : gClocksPerBitCheck
        $error("uart_rx_data_bits: ClockFrequency/BaudRate must be at least 4");
    end
    if (NrOfDataBits < 1 || NrOfDataBits > 16) begin : gDataBitsCheck
        $error("uart_rx_data_bits: NrOfDataBits must be within 1..16");
    end

    logic                    rxSync1_q;
    logic                    rxSync2_q;
    logic                    rxS;
    logic [1:0]              flush_q;
    logic [1:0]              flush_d;
    logic                    rxPrev_q;
    logic                    rxPrev_d;
    logic [1:0]              state_q;
    logic [1:0]              state_d;
    logic [CntW-1:0]         clkCnt_q;
    logic [CntW-1:0]         clkCnt_d;
    logic [BitW-1:0]         bitCnt_q;
    logic [BitW-1:0]         bitCnt_d;
    logic [NrOfDataBits-1:0] shift_q;
    logic [NrOfDataBits-1:0] shift_d;
    logic [NrOfDataBits-1:0] shiftIn;
    logic [NrOfDataBits-1:0] data_q;
    logic [NrOfDataBits-1:0] data_d;
    logic                    dataValid_q;
    logic                    dataValid_d;
    logic                    framingError_q;
    logic                    framingError_d;

    assign rxS = rxSync2_q;

    always_comb begin
        shiftIn                 = shift_q >> 1;
        shiftIn[NrOfDataBits-1] = rxS;
    end

    // rxPrev stays 0 until the synchroniser has flushed its reset value, so a
    // line held low through reset is not mistaken for a start bit.
    always_comb begin
        flush_d        = {flush_q[0], 1'b1};
        rxPrev_d       = flush_q[1] ? rxS : 1'b0;
        state_d        = state_q;
        clkCnt_d       = clkCnt_q;
        bitCnt_d       = bitCnt_q;
        shift_d        = shift_q;
        data_d         = data_q;
        dataValid_d    = 1'b0;
        framingError_d = 1'b0;

        case (state_q)
            StateIdle: begin
                if (rxPrev_q && !rxS) begin
                    state_d  = StateStart;
                    clkCnt_d = '0;
                    bitCnt_d = '0;
                end
            end
            StateStart: begin
                if (clkCnt_q == HalfClk) begin
                    clkCnt_d = '0;
                    state_d  = rxS ? StateIdle : StateData;
                end else begin
                    clkCnt_d = clkCnt_q + OneClk;
                end
            end
            StateData: begin
                if (clkCnt_q == LastClk) begin
                    clkCnt_d = '0;
                    shift_d  = shiftIn;
                    if (bitCnt_q == LastBit) begin
                        state_d = StateStop;
                    end else begin
                        bitCnt_d = bitCnt_q + OneBit;
                    end
                end else begin
                    clkCnt_d = clkCnt_q + OneClk;
                end
            end
            StateStop: begin
                // Leaving mid stop bit lets a back-to-back start edge be caught.
                if (clkCnt_q == LastClk) begin
                    clkCnt_d       = '0;
                    state_d        = StateIdle;
                    data_d         = shift_q;
                    dataValid_d    = rxS;
                    framingError_d = !rxS;
                end else begin
                    clkCnt_d = clkCnt_q + OneClk;
                end
            end
            default: begin
                state_d = StateIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rxSync1_q      <= 1'b1;
            rxSync2_q      <= 1'b1;
            flush_q        <= 2'b00;
            rxPrev_q       <= 1'b0;
            state_q        <= StateIdle;
            clkCnt_q       <= '0;
            bitCnt_q       <= '0;
            shift_q        <= '0;
            data_q         <= '0;
            dataValid_q    <= 1'b0;
            framingError_q <= 1'b0;
        end else begin
            rxSync1_q      <= rx;
            rxSync2_q      <= rxSync1_q;
            flush_q        <= flush_d;
            rxPrev_q       <= rxPrev_d;
            state_q        <= state_d;
            clkCnt_q       <= clkCnt_d;
            bitCnt_q       <= bitCnt_d;
            shift_q        <= shift_d;
            data_q         <= data_d;
            dataValid_q    <= dataValid_d;
            framingError_q <= framingError_d;
        end
    end

    assign data         = data_q;
    assign dataValid    = dataValid_q;
    assign framingError = framingError_q;
    assign busy         = (state_q != StateIdle) || dataValid_q || framingError_q;

endmodule

// File: doc/uart_rx_data_bits.md
Name: uart_rx_data_bits

Overview:
UART receiver that is the counterpart of the team's UART transmit chain. It deserialises one frame from the rx line: start bit (0), NrOfDataBits data bits LSB first, one stop bit (1). It presents the data word with a one-cycle valid pulse and flags framing errors. It sits between the board's serial input pin and the consumer logic, in the same clock domain as the transmitter.

Parameters:
ClockFrequency, 1000000, system clock frequency in Hz.
BaudRate, 9600, line bit rate in bits/s.
NrOfDataBits, 8, data bits per frame (1..16).

Ports:
clock  input  1  system clock; all logic on its rising edge.
reset  input  1  synchronous, active-low reset (0 = reset, sampled on the rising edge of clock).
rx  input  1  asynchronous serial line, idle high.
data  output  NrOfDataBits  last received word, LSB = first data bit on the line.
dataValid  output  1  one-cycle pulse: data holds a correctly framed word.
framingError  output  1  one-cycle pulse: stop bit sampled as 0.
busy  output  1  high while a frame is in progress (any state other than Idle).

Behaviour:
- Derived constants: ClocksPerBit = ClockFrequency/BaudRate (integer division); HalfBit = ClocksPerBit/2. ClocksPerBit must be at least 4; elaboration fails otherwise.
- rx is passed through a 2-flop synchroniser (both flops reset to 1). rxS is the second flop output. All decisions use rxS only.
- Reset (reset==0 at a clock edge): state=Idle, counters=0, data=0, dataValid=0, framingError=0, busy=0, synchroniser=1. Reset asserted mid-frame aborts the frame with no pulse. After reset releases, a new start bit is detected only after rxS has been seen high at least once.
- State machine (Idle, StartBit, DataBits, StopBit):
  - Idle: when rxS==0 and the previous rxS==1 (falling edge) -> StartBit, bit counter cleared, clock counter=0. Call this edge cycle T0.
  - StartBit: at T0+HalfBit, sample rxS. If 0 -> DataBits, clock counter restarts. If 1 (glitch) -> Idle, no pulse.
  - DataBits: sample every ClocksPerBit clocks. Data bit i is sampled at T0+HalfBit+ClocksPerBit*(i+1) and shifted in LSB-first. After bit NrOfDataBits-1 -> StopBit.
  - StopBit: sample at T0+HalfBit+ClocksPerBit*(NrOfDataBits+1). On the following cycle data is updated with the shift register, then:
    - stop bit==1: dataValid=1 for exactly one cycle.
    - stop bit==0: framingError=1 for exactly one cycle.
    - In both cases the state returns to Idle in that same cycle.
- dataValid and framingError are never high together. data holds its value until the next completed frame.
- Return to Idle happens mid stop bit, so back-to-back frames with a single stop bit are received without loss.
- Break condition (rx held at 0): one framingError, then no new frame until rxS has returned to 1 and fallen again.
- busy=1 from the cycle after the falling edge until the cycle dataValid/framingError is pulsed, inclusive.
- The block does not check parity, does not detect overrun, and has no ready/backpressure; the consumer must capture data on dataValid.

Test Plan:
1. Parameters 24_000_000 / 2_400_000 / 8 (ClocksPerBit=10, HalfBit=5). Send 0xBA (line order 0,0,1,0,1,1,1,0,1, stop 1) -> single dataValid pulse 96 clocks after the synced falling edge; data=8'hBA; framingError stays 0.
2. Same frame, stop bit driven 0 -> framingError pulse at the same cycle; data=8'hBA; dataValid stays 0.
3. rx low for 3 clocks, then high (glitch) -> back to Idle at HalfBit; no pulses; busy low afterwards. A following valid 0x55 frame is received correctly.
4. Back-to-back frames 0x01 then 0xFF, each with exactly one stop bit (no idle gap) -> two dataValid pulses 100 clocks apart; data=8'h01, then 8'hFF.
5. reset driven low for one clock in the middle of data bit 4 -> no pulse; data=0; busy=0. A subsequent 0xC3 frame is received correctly.
6. Line-rate tolerance: 0xA5 sent with bit period 10.4 clocks (+4%) and 9.6 clocks (-4%) -> both received as 8'hA5 with dataValid.
